// File: rtl/tt3_sweep_ctrl_if.sv
// Host/gate-side signal bundle for tt3_sweep_ctrl; the controller takes the slave modport.
interface tt3_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       gate_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic [7:0] tt;
    logic       match;
    logic [2:0] fail_row;

    modport master (
        output start, abort, expected, gate_out,
        input  in1, in2, in3, busy, done, tt, match, fail_row
    );

    modport slave (
        input  start, abort, expected, gate_out,
        output in1, in2, in3, busy, done, tt, match, fail_row
    );
endinterface

// File: rtl/tt3_sweep_ctrl.sv
// Sweeps the 8 rows of a 3-input gate, samples its output and checks the code (optional TT3_SWEEP_EARLY_STOP_EN).
// Latency: done 8*(SETTLE_CYCLES+1) edges after start is accepted (fewer with early stop).
// Backpressure: none; start is ignored while busy, abort cancels without a done pulse.
module tt3_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    tt3_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       row;
    logic [7:0]       tt_q;
    logic             match_q;
    logic [2:0]       fail_q;
    logic [7:0]       tt_smp;
    logic [2:0]       first_bad;

    // Code as it will look once the current row's sample is folded in.
    always_comb begin
        tt_smp = tt_q;
        tt_smp[3'd7 - row] = bus.gate_out;
    end

    always_comb begin
        first_bad = 3'd0;
        for (int r = 7; r >= 0; r--) begin
            if (tt_smp[7-r] != bus.expected[7-r]) first_bad = 3'(r);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.start && !bus.abort) state_nxt = SETTLE;
            SETTLE: begin
                if (bus.abort)            state_nxt = IDLE;
                else if (cnt == CNT_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (bus.abort)        state_nxt = IDLE;
                else if (row == 3'd7) state_nxt = DONE;
`ifdef TT3_SWEEP_EARLY_STOP_EN
                else if (bus.gate_out != bus.expected[3'd7 - row]) state_nxt = DONE;
`endif
                else                  state_nxt = SETTLE;
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row drives the gate directly from a flop, so inputs only move on row boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            row     <= 3'd0;
            tt_q    <= 8'h00;
            match_q <= 1'b0;
            fail_q  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == SETTLE) begin
                        cnt     <= '0;
                        row     <= 3'd0;
                        tt_q    <= 8'h00;
                        match_q <= 1'b0;
                        fail_q  <= 3'd0;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        row     <= 3'd0;
                        match_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (bus.abort) begin
                        row     <= 3'd0;
                        match_q <= 1'b0;
                    end else if (state_nxt == DONE) begin
                        // Verdict is registered on entry to DONE so it is valid alongside done.
                        tt_q    <= tt_smp;
                        match_q <= (tt_smp == bus.expected);
                        fail_q  <= first_bad;
                        row     <= 3'd0;
                    end else begin
                        tt_q <= tt_smp;
                        row  <= row + 3'd1;
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy     = (state == SETTLE) || (state == SAMPLE);
        bus.done     = (state == DONE);
        bus.in1      = row[2];
        bus.in2      = row[1];
        bus.in3      = row[0];
        bus.tt       = tt_q;
        bus.match    = match_q;
        bus.fail_row = fail_q;
    end

endmodule

// File: tb/tb_tt3_sweep_ctrl.sv
// Randomised sweeps of tt3_sweep_ctrl against a timeline model, plus literal anchors.
module tb_tt3_sweep_ctrl;

    localparam int S  = 4;
    localparam int RL = S + 1;
`ifdef TT3_SWEEP_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gate_code = 8'hEF;

    always #5 clk = ~clk;

    tt3_sweep_ctrl_if bus();

    assign bus.gate_out = gate_code[3'd7 - {bus.in1, bus.in2, bus.in3}];

    tt3_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: elapsed edges since start; row r is sampled on edge (r+1)*RL.
    bit         m_active;
    bit         m_done;
    int         m_t;
    int         m_r;
    bit         m_found;
    logic [7:0] m_tt;
    bit         m_match;
    logic [2:0] m_fail;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_t = 0; m_tt = 8'h00; m_match = 0; m_fail = 3'd0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (bus.start && !bus.abort) begin
                m_active = 1; m_t = 0; m_tt = 8'h00; m_match = 0; m_fail = 3'd0;
            end
        end else if (bus.abort) begin
            m_active = 0; m_match = 0;
        end else begin
            m_t++;
            if (m_t % RL == 0) begin
                m_r = m_t / RL - 1;
                m_tt[7-m_r] = gate_code[7-m_r];
                if (m_r == 7 || (EARLY && gate_code[7-m_r] != bus.expected[7-m_r])) begin
                    m_active = 0;
                    m_done   = 1;
                    m_match  = (m_tt == bus.expected);
                    m_fail   = 3'd0;
                    m_found  = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (!m_found && m_tt[7-i] != bus.expected[7-i]) begin
                            m_found = 1;
                            m_fail  = 3'(i);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", bus.busy, m_active);
            chk("done", bus.done, m_done);
            chk("row", {bus.in1, bus.in2, bus.in3}, m_active ? m_t / RL : 0);
            chk("tt", bus.tt, m_tt);
            chk("match", bus.match, m_match);
            if (m_done && !m_match) chk("fail_row", bus.fail_row, m_fail);
        end
    end

    function automatic int exp_lat(input logic [7:0] g, input logic [7:0] e);
        int n = 8;
        if (EARLY) begin
            for (int r = 7; r >= 0; r--) if (g[7-r] != e[7-r]) n = r + 1;
        end
        return n * RL;
    endfunction

    // lat = edges from start-accept to done, -1 if none within the window.
    task automatic sweep(input logic [7:0] g, input logic [7:0] e,
                         input int abort_at, input int restart_at, output int lat);
        gate_code    = g;
        bus.expected = e;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == restart_at) bus.start = 1'b0;
            if (k == abort_at) begin
                bus.abort = 1'b0;
                chk("abort_busy", bus.busy, 0);
                chk("abort_rows", {bus.in1, bus.in2, bus.in3}, 0);
                chk("abort_match", bus.match, 0);
            end
            if (bus.done && lat < 0) lat = k;
            if (lat >= 0) break;
            if (k + 1 == restart_at) bus.start = 1'b1;
            if (k + 1 == abort_at)   bus.abort = 1'b1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    int         lat;
    int         ab;
    int         rs;
    logic [7:0] g;
    logic [7:0] e;

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.expected = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rows", {bus.in1, bus.in2, bus.in3}, 0);
        chk("rst_tt", bus.tt, 8'h00);
        chk("rst_match", bus.match, 0);
        chk("rst_fail_row", bus.fail_row, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(8'hEF, 8'hEF, 0, 0, lat);
        chk("t1_latency", lat, 40);
        chk("t1_tt", bus.tt, 8'hEF);
        chk("t1_match", bus.match, 1);
        chk("t1_busy_with_done", bus.busy, 0);
        chk("t1_rows_at_done", {bus.in1, bus.in2, bus.in3}, 0);
        @(negedge clk);

        sweep(8'hEF, 8'hFF, 0, 0, lat);
        chk("t2_latency", lat, EARLY ? 20 : 40);
        chk("t2_tt", bus.tt, EARLY ? 8'hE0 : 8'hEF);
        chk("t2_match", bus.match, 0);
        chk("t2_fail_row", bus.fail_row, 3);
        @(negedge clk);

        sweep(8'hEF, 8'hEF, 17, 0, lat);
        chk("t4_no_done", lat, -1);
        chk("t4_tt_partial", bus.tt, 8'hE0);
        sweep(8'hEF, 8'hEF, 0, 0, lat);
        chk("t4_clean_latency", lat, 40);
        chk("t4_clean_match", bus.match, 1);
        @(negedge clk);

        sweep(8'hEF, 8'hEF, 0, 10, lat);
        chk("t5_restart_ignored", lat, 40);
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("t5_start_abort_idle", bus.busy, 0);
        @(negedge clk);
        chk("t5_still_idle", bus.busy, 0);

        gate_code = 8'hEF; bus.expected = 8'hEF;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_pre_tt", bus.tt, 8'h80);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_rows", {bus.in1, bus.in2, bus.in3}, 0);
        chk("t6_tt", bus.tt, 8'h00);
        chk("t6_match", bus.match, 0);
        chk("t6_fail_row", bus.fail_row, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_after", bus.busy, 0);
        sweep(8'h96, 8'h96, 0, 0, lat);
        chk("t6_clean_latency", lat, 40);
        @(negedge clk);

        repeat (30) begin
            g = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       e = g;
                1:       e = g ^ 8'(1 << $urandom_range(0, 7));
                default: e = 8'($urandom);
            endcase
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : 0;
            rs = (ab == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 39)) : 0;
            sweep(g, e, ab, rs, lat);
            if (ab == 0)                  chk("rand_latency", lat, exp_lat(g, e));
            else if (ab <= exp_lat(g, e)) chk("rand_abort_no_done", lat, -1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
